// File: rtl/spi_sensor_scheduler.sv
// Sensor byte scheduler for the SPI slave: arbitrates wind/water writes into shadows,
// commits them to the live bytes only while chip select is idle. Optional: STALE_TIMEOUT_EN.
module spi_sensor_scheduler #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 5000000,
    parameter int unsigned TW      = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              spi_done,
    input  logic              wind_valid,
    input  logic [DATA_W-1:0] wind_data,
    output logic              wind_ready,
    input  logic              water_valid,
    input  logic [DATA_W-1:0] water_data,
    output logic              water_ready,
    output logic [DATA_W-1:0] windsensor,
    output logic [DATA_W-1:0] watersensor,
    output logic              busy,
    output logic [7:0]        xfer_count,
    output logic [1:0]        stale
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Counter width must be able to hold TIMEOUT
    if ((64'(1) << TW) <= 64'(TIMEOUT)) begin : g_tw_check
        $error("TW too narrow for TIMEOUT");
    end

    state_t            state;
    logic [2:0]        cs_record;
    logic              cs_s;
    logic              done_d;
    logic              rr_water;
    logic              wind_pend;
    logic              water_pend;
    logic [DATA_W-1:0] wind_shadow;
    logic [DATA_W-1:0] water_shadow;
    logic              commit;

    assign cs_s   = cs_record[2];
    assign commit = (state == COMMIT) || ((state == IDLE) && cs_s);

    // Round-robin grant onto the shared shadow write port
    always_comb begin
        wind_ready  = 1'b0;
        water_ready = 1'b0;
        if (!rst) begin
            wind_ready  = wind_valid  & (~water_valid | ~rr_water);
            water_ready = water_valid & (~wind_valid  |  rr_water);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_record  <= 3'b111;
            done_d     <= 1'b0;
            xfer_count <= 8'd0;
        end else begin
            cs_record <= {cs_record[1:0], cs};
            done_d    <= spi_done;
            if (spi_done && !done_d) begin
                xfer_count <= xfer_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_water <= 1'b0;
        end else if (wind_valid && water_valid) begin
            rr_water <= ~rr_water;
        end
    end

    // Shadow capture and live commit; a same-edge accept keeps pending so the new byte commits next time
    always_ff @(posedge clk) begin
        if (rst) begin
            wind_shadow  <= '0;
            water_shadow <= '0;
            wind_pend    <= 1'b0;
            water_pend   <= 1'b0;
            windsensor   <= '0;
            watersensor  <= '0;
        end else begin
            if (commit) begin
                if (stale[0]) begin
                    windsensor <= {DATA_W{1'b1}};
                end else if (wind_pend) begin
                    windsensor <= wind_shadow;
                end
                if (stale[1]) begin
                    watersensor <= {DATA_W{1'b1}};
                end else if (water_pend) begin
                    watersensor <= water_shadow;
                end
            end

            if (wind_ready) begin
                wind_shadow <= wind_data;
                wind_pend   <= 1'b1;
            end else if (commit) begin
                wind_pend <= 1'b0;
            end

            if (water_ready) begin
                water_shadow <= water_data;
                water_pend   <= 1'b1;
            end else if (commit) begin
                water_pend <= 1'b0;
            end
        end
    end

    // Transaction lock FSM; busy mirrors the next state being LOCK
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state <= LOCK;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (cs_s) begin
                        state <= COMMIT;
                        busy  <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (!cs_s) begin
                        state <= LOCK;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALE_TIMEOUT_EN
    logic [TW-1:0] wind_age;
    logic [TW-1:0] water_age;
    logic [TW-1:0] wind_age_nxt;
    logic [TW-1:0] water_age_nxt;

    // Saturating age since last accepted write, cleared by an accept
    always_comb begin
        wind_age_nxt  = wind_age;
        water_age_nxt = water_age;
        if (wind_ready) begin
            wind_age_nxt = '0;
        end else if (wind_age != TW'(TIMEOUT)) begin
            wind_age_nxt = wind_age + TW'(1);
        end
        if (water_ready) begin
            water_age_nxt = '0;
        end else if (water_age != TW'(TIMEOUT)) begin
            water_age_nxt = water_age + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wind_age  <= '0;
            water_age <= '0;
            stale     <= 2'b00;
        end else begin
            wind_age  <= wind_age_nxt;
            water_age <= water_age_nxt;
            stale     <= {water_age_nxt == TW'(TIMEOUT), wind_age_nxt == TW'(TIMEOUT)};
        end
    end
`else
    assign stale = 2'b00;
`endif

endmodule

// File: tb/tb_spi_sensor_scheduler.sv
// Directed self-checking bench for spi_sensor_scheduler; stale checks only when STALE_TIMEOUT_EN is defined.
module tb_spi_sensor_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       spi_done;
    logic       wind_valid;
    logic [7:0] wind_data;
    logic       wind_ready;
    logic       water_valid;
    logic [7:0] water_data;
    logic       water_ready;
    logic [7:0] windsensor;
    logic [7:0] watersensor;
    logic       busy;
    logic [7:0] xfer_count;
    logic [1:0] stale;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef STALE_TIMEOUT_EN
    spi_sensor_scheduler #(.DATA_W(8), .TIMEOUT(20), .TW(5)) dut (
`else
    spi_sensor_scheduler dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .spi_done    (spi_done),
        .wind_valid  (wind_valid),
        .wind_data   (wind_data),
        .wind_ready  (wind_ready),
        .water_valid (water_valid),
        .water_data  (water_data),
        .water_ready (water_ready),
        .windsensor  (windsensor),
        .watersensor (watersensor),
        .busy        (busy),
        .xfer_count  (xfer_count),
        .stale       (stale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1ns after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b1; spi_done = 1'b0;
        wind_valid = 1'b0; wind_data = 8'h00;
        water_valid = 1'b0; water_data = 8'h00;
        step(2);
        check("rst_wind",  32'(windsensor),  32'h0);
        check("rst_water", 32'(watersensor), 32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_count", 32'(xfer_count),  32'h0);
        check("rst_stale", 32'(stale),       32'h0);
        rst = 1'b0;
        step(1);

        // Single wind write, live one edge after accept
        wind_valid = 1'b1; wind_data = 8'h3C;
        #1;
        check("t1_wind_ready",  32'(wind_ready),  32'h1);
        check("t1_water_ready", 32'(water_ready), 32'h0);
        step(1);
        wind_valid = 1'b0;
        check("t1_not_yet", 32'(windsensor), 32'h0);
        step(1);
        check("t1_live", 32'(windsensor), 32'h3C);

        // Contention alternates grants starting with wind
        wind_valid = 1'b1; wind_data = 8'h11;
        water_valid = 1'b1; water_data = 8'h22;
        #1;
        check("t2_g0_wind",  32'(wind_ready),  32'h1);
        check("t2_g0_water", 32'(water_ready), 32'h0);
        step(1);
        check("t2_g1_wind",  32'(wind_ready),  32'h0);
        check("t2_g1_water", 32'(water_ready), 32'h1);
        step(1);
        check("t2_g2_wind",  32'(wind_ready),  32'h1);
        check("t2_g2_water", 32'(water_ready), 32'h0);
        step(1);
        wind_valid = 1'b0; water_valid = 1'b0;
        step(2);
        check("t2_wind_live",  32'(windsensor),  32'h11);
        check("t2_water_live", 32'(watersensor), 32'h22);

        // Lock during cs low; water write held off until commit
        cs = 1'b0;
        step(3);
        check("t3_busy_pre", 32'(busy), 32'h0);
        step(1);
        check("t3_busy_on", 32'(busy), 32'h1);
        water_valid = 1'b1; water_data = 8'h55;
        #1;
        check("t3_water_ready", 32'(water_ready), 32'h1);
        step(1);
        water_valid = 1'b0;
        step(2);
        check("t3_frozen", 32'(watersensor), 32'h22);
        cs = 1'b1;
        step(3);
        check("t3_busy_hold", 32'(busy), 32'h1);
        step(1);
        check("t3_busy_off",   32'(busy),        32'h0);
        check("t3_still_old",  32'(watersensor), 32'h22);
        step(1);
        check("t3_commit",     32'(watersensor), 32'h55);
        check("t3_busy_idle",  32'(busy),        32'h0);

        // Transaction counter with wrap and level-held done
        for (int i = 0; i < 250; i++) begin
            spi_done = 1'b1; step(1);
            spi_done = 1'b0; step(1);
        end
        check("t4_250", 32'(xfer_count), 32'd250);
        for (int i = 0; i < 16; i++) begin
            spi_done = 1'b1; step(1);
            spi_done = 1'b0; step(1);
        end
        check("t4_wrap", 32'(xfer_count), 32'd10);
        spi_done = 1'b1; step(5);
        check("t4_held", 32'(xfer_count), 32'd11);
        spi_done = 1'b0; step(2);
        check("t4_fall", 32'(xfer_count), 32'd11);

        // Reset mid-transaction with cs held low
        cs = 1'b0;
        step(4);
        check("t5_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        step(2);
        check("t5_rst_wind",  32'(windsensor),  32'h0);
        check("t5_rst_water", 32'(watersensor), 32'h0);
        check("t5_rst_busy",  32'(busy),        32'h0);
        check("t5_rst_count", 32'(xfer_count),  32'h0);
        rst = 1'b0;
        step(3);
        check("t5_sync_delay", 32'(busy), 32'h0);
        step(1);
        check("t5_relock", 32'(busy), 32'h1);
        wind_valid = 1'b1; wind_data = 8'h5A;
        step(1);
        wind_valid = 1'b0;
        step(2);
        check("t5_frozen", 32'(windsensor), 32'h0);
        cs = 1'b1;
        step(4);
        check("t5_in_commit", 32'(windsensor), 32'h0);
        step(1);
        check("t5_commit", 32'(windsensor), 32'h5A);
        check("t5_stale", 32'(stale), 32'h0);

        // Accept coinciding with commit: live takes the old shadow
        wind_valid = 1'b1; wind_data = 8'h61;
        step(1);
        wind_data = 8'h62;
        step(1);
        wind_valid = 1'b0;
        check("t7_old_shadow", 32'(windsensor), 32'h61);
        step(1);
        check("t7_new_shadow", 32'(windsensor), 32'h62);

`ifdef STALE_TIMEOUT_EN
        // Wind goes stale after 20 idle cycles, recovers on write
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(19);
        check("t6_not_stale", 32'(stale[0]), 32'h0);
        step(1);
        check("t6_stale", 32'(stale[0]), 32'h1);
        check("t6_pre_ff", 32'(windsensor), 32'h0);
        step(1);
        check("t6_ff", 32'(windsensor), 32'hFF);
        wind_valid = 1'b1; wind_data = 8'h07;
        step(1);
        wind_valid = 1'b0;
        check("t6_cleared", 32'(stale[0]), 32'h0);
        step(1);
        check("t6_recover", 32'(windsensor), 32'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
